sequenciador_io: RTL and testbench

SEQUENCIADOR_IO -- requirements
Module: sequenciador_io

---
 rtl/sequenciador_io.sv | 163 ++++++++++++++++
 tb/tb_sequenciador_io.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_io.sv
// sequenciador_io: I/O sequencer for the processor's IN/OUT instructions.
// The input path stalls the PC, waits for a fresh press of the confirm
// button, then captures the switches and pulses a one-cycle register-bank
// write enable. The output path latches register data into the display.
// Optional feature: define DEBOUNCE_EN to filter the synchronized button
// level through a DEBOUNCE_CICLOS stability counter.
//
// Handshake: entradaPronta is a one-cycle valid strobe with no ready; the
// register bank must take dadoEntrada in the same cycle. pararPC stays high
// from the moment the input instruction is seen until the capture cycle.
module sequenciador_io #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        estagioEntradaUC,
    input  logic        estagioSaidaUC,
    input  logic        botao,
    input  logic [15:0] switches,
    input  logic [31:0] dadoSaida,
    output logic        pararPC,
    output logic [31:0] dadoEntrada,
    output logic        entradaPronta,
    output logic        aguardandoEntrada,
    output logic [31:0] display,
    output logic [1:0]  o_estado
);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESPERA_SOLTAR = 2'd1,
        ESPERA_PRESS  = 2'd2,
        FIM           = 2'd3
    } estado_t;

    estado_t     r_estado;
    logic        r_sinc1;
    logic        r_sinc2;
    logic        r_filtrado_ant;
    logic        r_pronto;
    logic        r_aguardando;
    logic [31:0] r_dado;
    logic [31:0] r_display;
    logic        w_filtrado;
    logic        w_press;

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
        end else begin
            r_sinc1 <= botao;
            r_sinc2 <= r_sinc1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CONT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

    logic [CONT_W-1:0] r_cont;
    logic              r_filtrado;

    // Accept a new level only after it disagrees with the filtered one for
    // DEBOUNCE_CICLOS consecutive edges; any agreement restarts the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cont     <= '0;
            r_filtrado <= 1'b0;
        end else if (r_sinc2 == r_filtrado) begin
            r_cont <= '0;
        end else if (r_cont == CONT_MAX) begin
            r_filtrado <= r_sinc2;
            r_cont     <= '0;
        end else begin
            r_cont <= r_cont + 1'b1;
        end
    end

    assign w_filtrado = r_filtrado;
`else
    assign w_filtrado = r_sinc2;
`endif

    // Previous filtered level, for rising-edge (press) detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_filtrado_ant <= 1'b0;
        end else begin
            r_filtrado_ant <= w_filtrado;
        end
    end

    assign w_press = w_filtrado & ~r_filtrado_ant;

    // Input-instruction FSM with registered pulse and waiting flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado     <= OCIOSO;
            r_dado       <= 32'd0;
            r_pronto     <= 1'b0;
            r_aguardando <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (estagioEntradaUC) begin
                        // A button already down must be released first.
                        r_estado     <= w_filtrado ? ESPERA_SOLTAR : ESPERA_PRESS;
                        r_aguardando <= 1'b1;
                    end
                end
                ESPERA_SOLTAR: begin
                    if (!estagioEntradaUC) begin
                        r_estado     <= OCIOSO;
                        r_aguardando <= 1'b0;
                    end else if (!w_filtrado) begin
                        r_estado <= ESPERA_PRESS;
                    end
                end
                ESPERA_PRESS: begin
                    if (!estagioEntradaUC) begin
                        r_estado     <= OCIOSO;
                        r_aguardando <= 1'b0;
                    end else if (w_press) begin
                        r_dado       <= {16'd0, switches};
                        r_estado     <= FIM;
                        r_pronto     <= 1'b1;
                        r_aguardando <= 1'b0;
                    end
                end
                FIM: begin
                    r_estado     <= OCIOSO;
                    r_aguardando <= 1'b0;
                end
                default: begin
                    r_estado     <= OCIOSO;
                    r_aguardando <= 1'b0;
                end
            endcase
        end
    end

    // Output path: latch register data whenever an output instruction runs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_display <= 32'd0;
        end else if (estagioSaidaUC) begin
            r_display <= dadoSaida;
        end
    end

    // The stall must rise in the same cycle the instruction is decoded, so
    // the idle term is combinational; all control outputs are masked in reset.
    assign pararPC           = reset & (r_aguardando | ((r_estado == OCIOSO) & estagioEntradaUC));
    assign entradaPronta     = reset & r_pronto;
    assign aguardandoEntrada = reset & r_aguardando;
    assign dadoEntrada       = r_dado;
    assign display           = r_display;
    assign o_estado          = r_estado;

endmodule

// File: tb/tb_sequenciador_io.sv
// Bench for sequenciador_io: hand-computed vector table, latency and
// debounce sequences, then randomized traffic against a reference model.
module tb_sequenciador_io;

`ifdef DEBOUNCE_EN
  localparam int DEB   = 4;
  localparam int EXTRA = 4;
`else
  localparam int DEB   = 4;
  localparam int EXTRA = 0;
`endif

  logic        clock;
  logic        rst;
  logic        ent;
  logic        sai;
  logic        b;
  logic [15:0] sw;
  logic [31:0] ds;
  logic        parar;
  logic [31:0] dado;
  logic        pronto;
  logic        aguard;
  logic [31:0] disp;
  logic [1:0]  estado;

  int n_checks = 0;
  int n_errors = 0;

  sequenciador_io #(.DEBOUNCE_CICLOS(DEB)) dut (
    .clock             (clock),
    .reset             (rst),
    .estagioEntradaUC  (ent),
    .estagioSaidaUC    (sai),
    .botao             (b),
    .switches          (sw),
    .dadoSaida         (ds),
    .pararPC           (parar),
    .dadoEntrada       (dado),
    .entradaPronta     (pronto),
    .aguardandoEntrada (aguard),
    .display           (disp),
    .o_estado          (estado)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  // Button path as sample histories; transaction as plain flags.
  bit          b_prev;
  bit          s_hist[$];
  bit          f_hist[$];
  bit          m_wait;
  bit          m_soltar;
  bit          m_fim;
  logic [31:0] m_dado;
  logic [31:0] m_disp;

  task automatic model_edge();
    bit fk1, fk2, press, s_new, f_new, flip;
    if (!rst) begin
      m_wait = 0; m_soltar = 0; m_fim = 0;
      m_dado = 32'd0; m_disp = 32'd0; b_prev = 0;
      s_hist.delete(); s_hist.push_back(1'b0);
      f_hist.delete(); f_hist.push_back(1'b0); f_hist.push_back(1'b0);
    end else begin
      fk1   = f_hist[f_hist.size()-1];
      fk2   = f_hist[f_hist.size()-2];
      press = fk1 && !fk2;
      if (m_fim) m_fim = 0;
      else if (!m_wait) begin
        if (ent) begin m_wait = 1; m_soltar = fk1; end
      end else if (!ent) begin
        m_wait = 0; m_soltar = 0;
      end else if (m_soltar) begin
        if (!fk1) m_soltar = 0;
      end else if (press) begin
        m_dado = {16'd0, sw}; m_wait = 0; m_fim = 1;
      end
      if (sai) m_disp = ds;
      s_new  = b_prev;
      b_prev = b;
`ifdef DEBOUNCE_EN
      flip = (s_hist.size() >= DEB);
      for (int i = 0; i < DEB; i++)
        if (flip && s_hist[s_hist.size()-1-i] == fk1) flip = 0;
      f_new = flip ? !fk1 : fk1;
`else
      flip  = 0;
      f_new = s_new | flip;
`endif
      s_hist.push_back(s_new);
      f_hist.push_back(f_new);
      if (s_hist.size() > 40) void'(s_hist.pop_front());
      if (f_hist.size() > 40) void'(f_hist.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic e, input logic s, input logic bb,
                       input logic [15:0] w, input logic [31:0] d);
    rst = r; ent = e; sai = s; b = bb; sw = w; ds = d;
    #1;
  endtask

  task automatic advance();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t state=%0d)", name, act, exp, $time, estado);
    end
  endtask

  task automatic check_model();
    logic e_parar, e_pronto, e_aguard;
    e_parar  = rst && (m_wait || (!m_fim && ent));
    e_pronto = rst && m_fim;
    e_aguard = rst && m_wait;
    check("parar",  {31'd0, parar},  {31'd0, e_parar});
    check("pronto", {31'd0, pronto}, {31'd0, e_pronto});
    check("aguard", {31'd0, aguard}, {31'd0, e_aguard});
    check("dado",   dado, m_dado);
    check("disp",   disp, m_disp);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst, ent, sai, b;
    logic [15:0] sw;
    logic [31:0] ds;
    logic        e_parar, e_pronto, e_aguard;
    logic [31:0] e_dado, e_disp;
  } vec_t;

  localparam int NV = 35;
  vec_t tab[NV];

  task automatic setv(input int i, input logic r, input logic e, input logic s, input logic bb,
                      input logic [15:0] w, input logic [31:0] d, input logic pp, input logic pr,
                      input logic ag, input logic [31:0] ed, input logic [31:0] ep);
    tab[i] = '{r, e, s, bb, w, d, pp, pr, ag, ed, ep};
  endtask

  initial begin
    int unsigned first;
    int          n_pulsos;
    int unsigned rnd;

    // basic input transaction with A5C3, then output DEADBEEF
    setv( 0, 1,1,0,0,16'hA5C3,32'h0,        1,0,0,32'h0,32'h0);
    setv( 1, 1,1,0,1,16'hA5C3,32'h0,        1,0,1,32'h0,32'h0);
    setv( 2, 1,1,0,1,16'hA5C3,32'h0,        1,0,1,32'h0,32'h0);
    setv( 3, 1,1,0,0,16'hA5C3,32'h0,        1,0,1,32'h0,32'h0);
    setv( 4, 1,0,0,0,16'hA5C3,32'h0,        0,1,0,32'hA5C3,32'h0);
    setv( 5, 1,0,1,0,16'h0,   32'hDEADBEEF, 0,0,0,32'hA5C3,32'h0);
    setv( 6, 1,0,0,0,16'h0,   32'h12345678, 0,0,0,32'hA5C3,32'hDEADBEEF);
    setv( 7, 1,0,0,0,16'h0,   32'h0,        0,0,0,32'hA5C3,32'hDEADBEEF);
    // button held before the instruction: release then fresh press
    setv( 8, 1,0,0,1,16'h1234,32'h0,        0,0,0,32'hA5C3,32'hDEADBEEF);
    setv( 9, 1,0,0,1,16'h1234,32'h0,        0,0,0,32'hA5C3,32'hDEADBEEF);
    setv(10, 1,1,0,1,16'h1234,32'h0,        1,0,0,32'hA5C3,32'hDEADBEEF);
    setv(11, 1,1,0,1,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(12, 1,1,0,1,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(13, 1,1,0,0,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(14, 1,1,0,0,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(15, 1,1,0,0,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(16, 1,1,0,1,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(17, 1,1,0,1,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(18, 1,1,0,0,16'h1234,32'h0,        1,0,1,32'hA5C3,32'hDEADBEEF);
    setv(19, 1,0,0,0,16'h1234,32'h0,        0,1,0,32'h1234,32'hDEADBEEF);
    // abort while waiting for the press
    setv(20, 1,1,0,0,16'hFFFF,32'h0,        1,0,0,32'h1234,32'hDEADBEEF);
    setv(21, 1,1,0,0,16'hFFFF,32'h0,        1,0,1,32'h1234,32'hDEADBEEF);
    setv(22, 1,0,0,1,16'hFFFF,32'h0,        1,0,1,32'h1234,32'hDEADBEEF);
    setv(23, 1,0,0,1,16'hFFFF,32'h0,        0,0,0,32'h1234,32'hDEADBEEF);
    setv(24, 1,0,0,0,16'hFFFF,32'h0,        0,0,0,32'h1234,32'hDEADBEEF);
    setv(25, 1,0,0,0,16'hFFFF,32'h0,        0,0,0,32'h1234,32'hDEADBEEF);
    setv(26, 1,0,0,0,16'hFFFF,32'h0,        0,0,0,32'h1234,32'hDEADBEEF);
    // input and output strobes overlapping
    setv(27, 1,1,1,0,16'h0042,32'hCAFEF00D, 1,0,0,32'h1234,32'hDEADBEEF);
    setv(28, 1,1,1,1,16'h0042,32'h0BADC0DE, 1,0,1,32'h1234,32'hCAFEF00D);
    setv(29, 1,1,0,1,16'h0042,32'h0,        1,0,1,32'h1234,32'h0BADC0DE);
    setv(30, 1,1,0,0,16'h0042,32'h0,        1,0,1,32'h1234,32'h0BADC0DE);
    setv(31, 1,0,0,0,16'h0042,32'h0,        0,1,0,32'h0042,32'h0BADC0DE);
    // reset in the middle of a wait
    setv(32, 1,1,0,0,16'h7777,32'h0,        1,0,0,32'h0042,32'h0BADC0DE);
    setv(33, 0,1,0,0,16'h7777,32'h0,        0,0,0,32'h0042,32'h0BADC0DE);
    setv(34, 1,0,0,0,16'h7777,32'h0,        0,0,0,32'h0,   32'h0);

    // reset
    drive(0, 0, 0, 0, 16'h0, 32'h0);
    for (int i = 0; i < 3; i++) advance();

    // reset state
    drive(1, 0, 0, 0, 16'h0, 32'h0);
    check("rst_parar",  {31'd0, parar},  32'd0);
    check("rst_pronto", {31'd0, pronto}, 32'd0);
    check("rst_aguard", {31'd0, aguard}, 32'd0);
    check("rst_dado",   dado, 32'd0);
    check("rst_disp",   disp, 32'd0);
    advance();

    // directed table
    for (int i = 0; i < NV; i++) begin
      drive(tab[i].rst, tab[i].ent, tab[i].sai, tab[i].b, tab[i].sw, tab[i].ds);
`ifdef DEBOUNCE_EN
      check_model();
`else
      check($sformatf("v%0d_parar", i),  {31'd0, parar},  {31'd0, tab[i].e_parar});
      check($sformatf("v%0d_pronto", i), {31'd0, pronto}, {31'd0, tab[i].e_pronto});
      check($sformatf("v%0d_aguard", i), {31'd0, aguard}, {31'd0, tab[i].e_aguard});
      check($sformatf("v%0d_dado", i),   dado, tab[i].e_dado);
      check($sformatf("v%0d_disp", i),   disp, tab[i].e_disp);
`endif
      advance();
    end

    // press latency: 5-cycle press, first pronto counted from the first
    // edge that samples botao=1
    drive(1, 0, 0, 0, 16'h0, 32'h0);
    for (int i = 0; i < 2 * DEB + 4; i++) begin check_model(); advance(); end
    drive(1, 1, 0, 0, 16'h3C3C, 32'h0);
    check_model(); advance();
    first = 32'hFFFF_FFFF;
    for (int j = 0; j < 30; j++) begin
      drive(1, (first == 32'hFFFF_FFFF), 0, (j < 5), 16'h3C3C, 32'h0);
      check_model();
      if (pronto && first == 32'hFFFF_FFFF) first = j;
      advance();
    end
    check("latencia", first, 32'(3 + EXTRA));
    check("lat_dado", dado, 32'h0000_3C3C);

`ifdef DEBOUNCE_EN
    // a 3-cycle glitch must not complete the input
    drive(1, 0, 0, 0, 16'h0, 32'h0);
    for (int i = 0; i < 12; i++) begin check_model(); advance(); end
    n_pulsos = 0;
    for (int j = 0; j < 16; j++) begin
      drive(1, 1, 0, (j >= 1 && j < 4), 16'h5555, 32'h0);
      check_model();
      if (pronto) n_pulsos++;
      advance();
    end
    check("glitch_pulsos", n_pulsos, 32'd0);
    check("glitch_aguard", {31'd0, aguard}, 32'd1);
`endif

    // randomized traffic against the model
    drive(1, 0, 0, 0, 16'h0, 32'h0);
    n_pulsos = 0;
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom_range(0, 3);
      logic_next: begin
        logic nr, ne, nb;
        nr = ($urandom_range(0, 299) != 0);
        ne = ($urandom_range(0, 7) == 0) ? ~ent : ent;
        nb = (rnd == 0) ? ~b : b;
        drive(nr, ne, ($urandom_range(0, 2) == 0), nb,
              16'($urandom), $urandom);
      end
      check_model();
      if (pronto) n_pulsos++;
      advance();
    end
    check("rand_houve_capturas", {31'd0, (n_pulsos > 5)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
